alu_muldiv_seq: RTL

- Parametrised, multi-cycle multiply/divide unit that sits beside the combinational ALU in the EX stage of the pipelined CPU.
- Computes signed/unsigned MULT and DIV results into internal HI/LO registers using a one-bit-per-cycle iterative datapath.
- Exposes a start/busy/done handshake so the hazard unit can stall dependent MFHI/MFLO reads.
- Also supports direct MTHI/MTLO writes and a pipeline-flush cancel.

---
 rtl/alu_muldiv_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU into HI/LO,
// one bit per cycle, with start/busy/done handshake, MTHI/MTLO writes and flush cancel.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       sig_md_op,
    input  logic             sig_md_start,
    input  logic             sig_md_cancel,
    input  logic             sig_hi_we,
    input  logic             sig_lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   opd_b;

    logic               start_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign start_signed = ~sig_md_op[0];
    assign busy         = (state != ST_IDLE);

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd_b} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        // Modulo WIDTH+1 bits, bit WIDTH is set exactly when the trial subtraction underflows.
        div_diff  = div_shift - {1'b0, opd_b};
        prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_a ? -rem : rem;
        if (opd_b == '0) begin
            quo_fix = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            rem    <= '0;
            opd_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sig_hi_we) hi <= wr_data;
                    if (sig_lo_we) lo <= wr_data;
                    if (sig_md_start && !sig_md_cancel) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        op     <= sig_md_op;
                        sign_a <= start_signed & src_a[WIDTH-1];
                        sign_b <= start_signed & src_b[WIDTH-1];
                        acc    <= {{WIDTH{1'b0}},
                                   (start_signed & src_a[WIDTH-1]) ? -src_a : src_a};
                        opd_b  <= (start_signed & src_b[WIDTH-1]) ? -src_b : src_b;
                        rem    <= '0;
                    end
                end
                ST_RUN: begin
                    if (sig_md_cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        if (op[1]) begin
                            rem <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH]};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!sig_md_cancel) begin
                        done <= 1'b1;
                        if (op[1]) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
